// File: rtl/jmb_mad_pkg.sv
// Shared definitions for the jmb_mad2 multiply-add stage and its block accumulator.
package jmb_mad_pkg;

    localparam int MAD_DATA_W = 32;
    localparam int MAD_ACC_W  = 40;
    localparam int MAD_LEN_W  = 8;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

endpackage

// File: rtl/jmb_mad_accum_if.sv
// Sample-in / result-out handshake bundle for jmb_mad_accum, plus block control.
interface jmb_mad_accum_if
    import jmb_mad_pkg::*;
#(
    parameter int DATA_W = MAD_DATA_W,
    parameter int ACC_W  = MAD_ACC_W,
    parameter int LEN_W  = MAD_LEN_W
);
    logic [LEN_W-1:0]  len;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [LEN_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output len, clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  len, clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/jmb_mad_accum.sv
// Accumulates a programmable number of mad2 results into a wide sum and emits
// one result per block with the sample count and a sticky carry-out flag.
module jmb_mad_accum
    import jmb_mad_pkg::*;
#(
    parameter int DATA_W = MAD_DATA_W,
    parameter int ACC_W  = MAD_ACC_W,
    parameter int LEN_W  = MAD_LEN_W
) (
    input  logic clock,
    input  logic reset,
    jmb_mad_accum_if.slave bus
);

    state_t            state, state_next;
    logic [ACC_W-1:0]  acc;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len_q;
    logic              ovf;
    logic              out_valid_q;
    logic [ACC_W-1:0]  out_sum_q;
    logic [LEN_W-1:0]  out_count_q;
    logic              out_ovf_q;

    logic              ready;
    logic              accept;
    logic              last;
    logic              carry;
    logic [ACC_W:0]    sum;
    logic [LEN_W-1:0]  eff_len;
    logic [LEN_W:0]    cnt_inc;

    always_comb begin
        state_next = state;
        ready      = (state == ST_ACCUM);
        // Block length is taken live from len only on the first sample of a block.
        if (cnt == '0)
            eff_len = (bus.len == '0) ? LEN_W'(1) : bus.len;
        else
            eff_len = len_q;
        sum     = {1'b0, acc} + (ACC_W+1)'(bus.in_data);
        carry   = sum[ACC_W];
        cnt_inc = {1'b0, cnt} + (LEN_W+1)'(1);
        accept  = bus.in_valid && ready;
        last    = accept && !bus.clear && (cnt_inc == {1'b0, eff_len});
        case (state)
            ST_ACCUM: if (last) state_next = ST_HOLD;
            ST_HOLD:  if (bus.out_ready) state_next = ST_ACCUM;
            default:  state_next = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_ACCUM;
            acc         <= '0;
            cnt         <= '0;
            ovf         <= 1'b0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state       <= state_next;
            out_valid_q <= (state_next == ST_HOLD);
            if (state == ST_ACCUM) begin
                if (bus.clear) begin
                    acc <= '0;
                    cnt <= '0;
                    ovf <= 1'b0;
                end else if (last) begin
                    out_sum_q   <= sum[ACC_W-1:0];
                    out_count_q <= eff_len;
                    out_ovf_q   <= ovf | carry;
                    acc         <= '0;
                    cnt         <= '0;
                    ovf         <= 1'b0;
                end else if (accept) begin
                    acc <= sum[ACC_W-1:0];
                    ovf <= ovf | carry;
                    cnt <= cnt_inc[LEN_W-1:0];
                    if (cnt == '0)
                        len_q <= eff_len;
                end
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule
